// File: rtl/signed_seq_divider.sv
// signed_seq_divider: multi-cycle signed restoring divider.
// Divides a signed N-bit dividend by a signed M-bit divisor and produces a
// quotient truncated toward zero plus a remainder carrying the dividend's
// sign. Operation is launched with start and reported with a one-cycle done
// pulse; busy covers the iteration and sign-fixup cycles.
module signed_seq_divider #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // Captured operands; kept for the sign fixup and the flag decode.
  logic [N-1:0]  a_reg;
  logic [M-1:0]  b_reg;
  // Dividend magnitude shifts out of the top while quotient bits shift in at
  // the bottom. N unsigned bits are enough to hold the magnitude 2^(N-1).
  logic [N-1:0]  q_sh;
  // Divisor magnitude, one bit wider so that -2^(M-1) is representable.
  logic [M:0]    b_mag;
  // Partial remainder; always below |divisor| <= 2^(M-1) between iterations.
  logic [M-1:0]  pr;
  logic [CW-1:0] cnt;

  // Per-iteration restoring step.
  logic [M:0]    pr_shift;
  logic          pr_ge;
  logic [M-1:0]  pr_next;

  // Sign fixup / flag decode used in FIX.
  logic          sa;
  logic          sb;
  logic          dbz;
  logic          ovf;
  logic [N-1:0]  q_signed;
  logic [M-1:0]  r_signed;

  // One restoring-division step: shift in next dividend bit, trial subtract.
  always_comb begin
    pr_shift = {pr, q_sh[N-1]};
    pr_ge    = (pr_shift >= b_mag);
    pr_next  = pr_ge ? M'(pr_shift - b_mag) : pr_shift[M-1:0];
  end

  // Sign restoration of the magnitudes and the special-case flags.
  always_comb begin
    sa       = a_reg[N-1];
    sb       = b_reg[M-1];
    dbz      = (b_reg == '0);
    ovf      = (a_reg == {1'b1, {(N-1){1'b0}}}) && (b_reg == '1);
    q_signed = (sa ^ sb) ? -q_sh : q_sh;
    r_signed = sa ? -pr : pr;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == CW'(N - 1)) begin
          state_next = FIX;
        end
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, iteration, and result/flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg       <= '0;
      b_reg       <= '0;
      q_sh        <= '0;
      b_mag       <= '0;
      pr          <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= dividend;
            b_reg <= divisor;
            q_sh  <= dividend[N-1] ? -dividend : dividend;
            b_mag <= divisor[M-1] ? -{divisor[M-1], divisor} : {1'b0, divisor};
            pr    <= '0;
            cnt   <= '0;
          end
        end
        CALC: begin
          pr   <= pr_next;
          q_sh <= {q_sh[N-2:0], pr_ge};
          cnt  <= cnt + CW'(1);
        end
        FIX: begin
          // Divide by zero forces -1 / 0; the overflow case needs no
          // override because the negated magnitude wraps to -2^(N-1).
          quotient    <= dbz ? '1 : q_signed;
          remainder   <= dbz ? '0 : r_signed;
          div_by_zero <= dbz;
          overflow    <= ovf;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_seq_divider.sv
// tb_signed_seq_divider: scoreboard bench for signed_seq_divider (N=8, M=4).
module tb_signed_seq_divider;

  localparam int N = 8;
  localparam int M = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  typedef struct {
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         dbz;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   dones = 0;

  signed_seq_divider #(.N(N), .M(M)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t model(input logic [N-1:0] a, input logic [M-1:0] b);
    exp_t m;
    int   ai;
    int   bi;
    ai = $signed(a);
    bi = $signed(b);
    m.dbz = 1'b0;
    m.ovf = 1'b0;
    if (bi == 0) begin
      m.q   = '1;
      m.r   = '0;
      m.dbz = 1'b1;
    end else if (ai == -128 && bi == -1) begin
      m.q   = 8'h80;
      m.r   = '0;
      m.ovf = 1'b1;
    end else begin
      m.q = 8'(ai / bi);
      m.r = 4'(ai % bi);
    end
    return m;
  endfunction

  // Scoreboard: every done pops one expectation and compares all results.
  always @(negedge clk) begin
    if (rst_n && done) begin
      dones++;
      if (sb_q.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("txn q=%02h r=%01h dbz=%0b ovf=%0b (exp q=%02h r=%01h dbz=%0b ovf=%0b)",
                 quotient, remainder, div_by_zero, overflow, e.q, e.r, e.dbz, e.ovf);
        check("quotient", {24'd0, quotient}, {24'd0, e.q});
        check("remainder", {28'd0, remainder}, {28'd0, e.r});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        check("overflow", {31'd0, overflow}, {31'd0, e.ovf});
      end
    end
  end

  // Called at a negedge while idle; returns at the first negedge after acceptance.
  task automatic issue(input logic [N-1:0] a, input logic [M-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb_q.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Current negedge is cycle 1 after acceptance; returns at the done negedge.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic run(input logic [N-1:0] a, input logic [M-1:0] b);
    int lat;
    int bcnt;
    issue(a, b);
    wait_done(lat, bcnt);
    check("latency", lat, N + 2);
    check("busy_cycles", bcnt, N + 1);
    check("busy_in_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int bcnt;
    int d0;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", {24'd0, quotient}, 32'd0);
    check("rst_remainder", {28'd0, remainder}, 32'd0);
    check("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and sign combinations with magnitudes 100/7.
    run(8'h64, 4'h7);
    run(8'h9C, 4'h7);
    run(8'h64, 4'h9);
    run(8'h9C, 4'h9);

    // Boundaries.
    run(8'h05, 4'h0);
    run(8'h80, 4'h1);
    run(8'h7F, 4'h8);
    run(8'h80, 4'h8);
    run(8'h80, 4'hF);

    // Asynchronous reset in the middle of CALC (previous result left overflow=1).
    issue(8'h64, 4'h7);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quotient", {24'd0, quotient}, 32'd0);
    check("midrst_remainder", {28'd0, remainder}, 32'd0);
    check("midrst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    sb_q.delete();
    d0 = dones;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst_no_done", dones - d0, 0);
    run(8'h64, 4'h7);

    // start held high with operands changing while busy.
    start    = 1'b1;
    dividend = 8'h64;
    divisor  = 4'h7;
    sb_q.push_back(model(8'h64, 4'h7));
    d0 = dones;
    @(negedge clk);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    check("hold_latency", lat, N + 2);
    repeat (15) @(negedge clk);
    check("hold_done_count", dones - d0, 1);

    // start raised in the DONE cycle: ignored there, accepted in the next IDLE.
    issue(8'h14, 4'h3);
    wait_done(lat, bcnt);
    check("pre_latency", lat, N + 2);
    start    = 1'b1;
    dividend = 8'h64;
    divisor  = 4'h7;
    sb_q.push_back(model(8'h64, 4'h7));
    @(negedge clk);
    check("done_start_ignored", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("idle_start_taken", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done(lat, bcnt);
    check("late_latency", lat, N + 2);
    @(negedge clk);

    // Multiplier inverse sweep: (A*B)/B must give A with zero remainder.
    for (int a = -8; a <= 7; a++) begin
      for (int b = -8; b <= 7; b++) begin
        if (b != 0) begin
          run(8'(a * b), 4'(b));
        end
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
